// File: rtl/regfile_wb_queue_if.sv
// Write-back queue bus: two producer request channels, the register file
// write port, two forwarding lookups and queue status.
interface regfile_wb_queue_if #(
    parameter int DATA_W = 34,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Source A (ALU result path)
    logic              a_valid_i;
    logic [ADDR_W-1:0] a_addr_i;
    logic [DATA_W-1:0] a_data_i;
    logic              a_ready_o;

    // Source B (load / multi-cycle path)
    logic              b_valid_i;
    logic [ADDR_W-1:0] b_addr_i;
    logic [DATA_W-1:0] b_data_i;
    logic              b_ready_o;

    // Register file write port
    logic [ADDR_W-1:0] rf_addr3_o;
    logic [DATA_W-1:0] rf_data3_o;
    logic              rf_we3_o;

    // Forwarding lookups
    logic [ADDR_W-1:0] lk_addr1_i;
    logic [ADDR_W-1:0] lk_addr2_i;
    logic              lk_hit1_o;
    logic [DATA_W-1:0] lk_data1_o;
    logic              lk_hit2_o;
    logic [DATA_W-1:0] lk_data2_o;

    // Status
    logic [CNT_W-1:0]  count_o;
    logic              full_o;
    logic              empty_o;

    // Queue side
    modport slave (
        input  a_valid_i, a_addr_i, a_data_i,
        output a_ready_o,
        input  b_valid_i, b_addr_i, b_data_i,
        output b_ready_o,
        output rf_addr3_o, rf_data3_o, rf_we3_o,
        input  lk_addr1_i, lk_addr2_i,
        output lk_hit1_o, lk_data1_o, lk_hit2_o, lk_data2_o,
        output count_o, full_o, empty_o
    );

    // Producer / consumer side
    modport master (
        output a_valid_i, a_addr_i, a_data_i,
        input  a_ready_o,
        output b_valid_i, b_addr_i, b_data_i,
        input  b_ready_o,
        input  rf_addr3_o, rf_data3_o, rf_we3_o,
        output lk_addr1_i, lk_addr2_i,
        input  lk_hit1_o, lk_data1_o, lk_hit2_o, lk_data2_o,
        input  count_o, full_o, empty_o
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// Register file write-back queue: accepts up to two write requests per cycle
// (A older than B), drains one per cycle to the register file write port in
// order, and forwards the youngest queued value for two lookup addresses.
module regfile_wb_queue #(
    parameter int DATA_W = 34,
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic clk,
    input  logic rst_n,
    regfile_wb_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE_LEFT = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_TWO_LEFT = CNT_W'(DEPTH - 2);

    // Entry storage; no reset needed, validity comes from pointers and count
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;

    logic             a_ready, b_ready;
    logic             enq_a, enq_b, deq;
    logic [PTR_W-1:0] wr_ptr_b;

    logic [DEPTH-1:0] slot_valid;
    logic [DEPTH-1:0] hit1_vec, hit2_vec;

    // Acceptance looks only at the occupancy at the start of the cycle;
    // the same-cycle pop never makes room for an incoming request.
    assign a_ready = (count_reg <= CNT_ONE_LEFT);
    assign b_ready = (count_reg <= CNT_TWO_LEFT) ||
                     ((count_reg == CNT_ONE_LEFT) && !bus.a_valid_i);
    assign enq_a   = bus.a_valid_i && a_ready;
    assign enq_b   = bus.b_valid_i && b_ready;
    assign deq     = (count_reg != '0);

    // B lands behind A when both are accepted together
    assign wr_ptr_b = wr_ptr_reg + PTR_W'(enq_a);

    // Pointer and occupancy next-state
    always_comb begin
        count_next  = count_reg + CNT_W'(enq_a) + CNT_W'(enq_b) - CNT_W'(deq);
        rd_ptr_next = rd_ptr_reg + PTR_W'(deq);
        wr_ptr_next = wr_ptr_b + PTR_W'(enq_b);
    end

    // Queue control state, cleared asynchronously so pending entries vanish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Entry write: A and B go to consecutive slots
    always_ff @(posedge clk) begin
        if (enq_a) begin
            addr_mem[wr_ptr_reg] <= bus.a_addr_i;
            data_mem[wr_ptr_reg] <= bus.a_data_i;
        end
        if (enq_b) begin
            addr_mem[wr_ptr_b] <= bus.b_addr_i;
            data_mem[wr_ptr_b] <= bus.b_data_i;
        end
    end

    // Per-slot validity (age below occupancy) and lookup address matches
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [PTR_W-1:0] age;
            assign age            = PTR_W'(gi) - rd_ptr_reg;
            assign slot_valid[gi] = ({1'b0, age} < count_reg);
            assign hit1_vec[gi]   = slot_valid[gi] && (addr_mem[gi] == bus.lk_addr1_i);
            assign hit2_vec[gi]   = slot_valid[gi] && (addr_mem[gi] == bus.lk_addr2_i);
        end
    endgenerate

    // Forwarding: walk oldest to youngest so the youngest match wins
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx            = rd_ptr_reg;
        bus.lk_hit1_o  = 1'b0;
        bus.lk_data1_o = '0;
        bus.lk_hit2_o  = 1'b0;
        bus.lk_data2_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_reg + PTR_W'(k);
            if (hit1_vec[idx]) begin
                bus.lk_hit1_o  = 1'b1;
                bus.lk_data1_o = data_mem[idx];
            end
            if (hit2_vec[idx]) begin
                bus.lk_hit2_o  = 1'b1;
                bus.lk_data2_o = data_mem[idx];
            end
        end
    end

    // Write port presents the head whenever the queue holds anything
    assign bus.rf_we3_o   = deq;
    assign bus.rf_addr3_o = deq ? addr_mem[rd_ptr_reg] : '0;
    assign bus.rf_data3_o = deq ? data_mem[rd_ptr_reg] : '0;

    assign bus.a_ready_o = a_ready;
    assign bus.b_ready_o = b_ready;
    assign bus.count_o   = count_reg;
    assign bus.full_o    = (count_reg == CNT_FULL);
    assign bus.empty_o   = (count_reg == '0);
endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: per-cycle vector table, mid-operation reset
// sequence, and a random dual-source stream against a reference queue.
module tb_regfile_wb_queue;
    localparam int DATA_W = 34;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 4;

    logic clk;
    logic rst_n;

    regfile_wb_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    regfile_wb_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        av;  logic [4:0] aa;  logic [33:0] ad;
        logic        bv;  logic [4:0] ba;  logic [33:0] bd;
        logic [4:0]  l1;  logic [4:0] l2;
        logic        ear; logic ebr; logic ewe;
        logic [4:0]  ewa; logic [33:0] ewd;
        logic        eh1; logic [33:0] ed1;
        logic        eh2; logic [33:0] ed2;
        logic [2:0]  ecnt;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [33:0] data;
    } ent_t;

    localparam int NV = 18;
    vec_t tbl [NV];
    ent_t sb [$];

    function automatic vec_t mk(
        input int av, input int aa, input longint ad,
        input int bv, input int ba, input longint bd,
        input int l1, input int l2,
        input int ear, input int ebr, input int ewe, input int ewa, input longint ewd,
        input int eh1, input longint ed1, input int eh2, input longint ed2,
        input int ecnt);
        vec_t v;
        v.av = av[0];  v.aa = 5'(aa);  v.ad = 34'(ad);
        v.bv = bv[0];  v.ba = 5'(ba);  v.bd = 34'(bd);
        v.l1 = 5'(l1); v.l2 = 5'(l2);
        v.ear = ear[0]; v.ebr = ebr[0]; v.ewe = ewe[0];
        v.ewa = 5'(ewa); v.ewd = 34'(ewd);
        v.eh1 = eh1[0]; v.ed1 = 34'(ed1);
        v.eh2 = eh2[0]; v.ed2 = 34'(ed2);
        v.ecnt = 3'(ecnt);
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [33:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [33:0] bd,
                         input logic [4:0] l1, input logic [4:0] l2);
        bus.a_valid_i = av; bus.a_addr_i = aa; bus.a_data_i = ad;
        bus.b_valid_i = bv; bus.b_addr_i = ba; bus.b_data_i = bd;
        bus.lk_addr1_i = l1; bus.lk_addr2_i = l2;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 34'd0, 1'b0, 5'd0, 34'd0, 5'd0, 5'd0);
    endtask

    initial begin
        // Expected values reflect queue state at the start of each cycle.
        // With the drain always active, occupancy tops out at DEPTH-1.
        tbl[0]  = mk(0, 0, 0,              0, 0, 0,      0, 0,   1,1,0, 0,0,                0,0,                0,0,      0);
        tbl[1]  = mk(1, 3, 64'h200000001,  0, 0, 0,      0, 0,   1,1,0, 0,0,                0,0,                0,0,      0);
        tbl[2]  = mk(0, 0, 0,              0, 0, 0,      3, 4,   1,1,1, 3,64'h200000001,    1,64'h200000001,    0,0,      1);
        tbl[3]  = mk(0, 0, 0,              0, 0, 0,      3, 4,   1,1,0, 0,0,                0,0,                0,0,      0);
        tbl[4]  = mk(1, 5, 'h11,           1, 6, 'h22,   0, 0,   1,1,0, 0,0,                0,0,                0,0,      0);
        tbl[5]  = mk(0, 0, 0,              0, 0, 0,      5, 6,   1,1,1, 5,'h11,             1,'h11,             1,'h22,   2);
        tbl[6]  = mk(0, 0, 0,              0, 0, 0,      5, 6,   1,1,1, 6,'h22,             0,0,                1,'h22,   1);
        tbl[7]  = mk(1, 8, 'h100,          1, 9, 'h101,  0, 0,   1,1,0, 0,0,                0,0,                0,0,      0);
        tbl[8]  = mk(1,10, 'h102,          1,11, 'h103,  9, 8,   1,1,1, 8,'h100,            1,'h101,            1,'h100,  2);
        tbl[9]  = mk(1,12, 'h104,          1,13, 'h105, 10,13,   1,0,1, 9,'h101,            1,'h102,            0,0,      3);
        tbl[10] = mk(1,14, 'h106,          1,13, 'h105, 12,14,   1,0,1,10,'h102,            1,'h104,            0,0,      3);
        tbl[11] = mk(0, 0, 0,              1,13, 'h105, 14,11,   1,1,1,11,'h103,            1,'h106,            1,'h103,  3);
        tbl[12] = mk(1, 7, 'hA,            0, 0, 0,     13,12,   1,0,1,12,'h104,            1,'h105,            1,'h104,  3);
        tbl[13] = mk(1, 7, 'hB,            0, 0, 0,      7, 8,   1,0,1,14,'h106,            1,'hA,              0,0,      3);
        tbl[14] = mk(0, 0, 0,              0, 0, 0,      7, 7,   1,1,1,13,'h105,            1,'hB,              1,'hB,    3);
        tbl[15] = mk(0, 0, 0,              0, 0, 0,      7, 8,   1,1,1, 7,'hA,              1,'hB,              0,0,      2);
        tbl[16] = mk(0, 0, 0,              0, 0, 0,      7, 8,   1,1,1, 7,'hB,              1,'hB,              0,0,      1);
        tbl[17] = mk(0, 0, 0,              0, 0, 0,      7, 8,   1,1,0, 0,0,                0,0,                0,0,      0);

        // Reset state
        rst_n = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        #1;
        chk("rst.we",    64'(bus.rf_we3_o),   64'd0);
        chk("rst.addr",  64'(bus.rf_addr3_o), 64'd0);
        chk("rst.data",  64'(bus.rf_data3_o), 64'd0);
        chk("rst.count", 64'(bus.count_o),    64'd0);
        chk("rst.empty", 64'(bus.empty_o),    64'd1);
        chk("rst.full",  64'(bus.full_o),     64'd0);
        chk("rst.ar",    64'(bus.a_ready_o),  64'd1);
        chk("rst.br",    64'(bus.b_ready_o),  64'd1);
        chk("rst.hit1",  64'(bus.lk_hit1_o),  64'd0);
        chk("rst.data1", 64'(bus.lk_data1_o), 64'd0);
        chk("rst.hit2",  64'(bus.lk_hit2_o),  64'd0);
        chk("rst.data2", 64'(bus.lk_data2_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: drive on the falling edge, check just after
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].ba, tbl[i].bd,
                  tbl[i].l1, tbl[i].l2);
            #1;
            chk($sformatf("v%0d.ar", i),    64'(bus.a_ready_o),  64'(tbl[i].ear));
            chk($sformatf("v%0d.br", i),    64'(bus.b_ready_o),  64'(tbl[i].ebr));
            chk($sformatf("v%0d.we", i),    64'(bus.rf_we3_o),   64'(tbl[i].ewe));
            chk($sformatf("v%0d.addr", i),  64'(bus.rf_addr3_o), 64'(tbl[i].ewa));
            chk($sformatf("v%0d.data", i),  64'(bus.rf_data3_o), 64'(tbl[i].ewd));
            chk($sformatf("v%0d.hit1", i),  64'(bus.lk_hit1_o),  64'(tbl[i].eh1));
            chk($sformatf("v%0d.data1", i), 64'(bus.lk_data1_o), 64'(tbl[i].ed1));
            chk($sformatf("v%0d.hit2", i),  64'(bus.lk_hit2_o),  64'(tbl[i].eh2));
            chk($sformatf("v%0d.data2", i), 64'(bus.lk_data2_o), 64'(tbl[i].ed2));
            chk($sformatf("v%0d.count", i), 64'(bus.count_o),    64'(tbl[i].ecnt));
            chk($sformatf("v%0d.full", i),  64'(bus.full_o),     64'(tbl[i].ecnt == 3'd4));
            chk($sformatf("v%0d.empty", i), 64'(bus.empty_o),    64'(tbl[i].ecnt == 3'd0));
        end

        // Mid-operation reset with three entries pending
        @(negedge clk);
        drive(1'b1, 5'd1, 34'h1, 1'b1, 5'd2, 34'h2, 5'd0, 5'd0);
        @(negedge clk);
        drive(1'b1, 5'd3, 34'h3, 1'b1, 5'd4, 34'h4, 5'd0, 5'd0);
        @(negedge clk);
        drive(1'b0, 5'd0, 34'd0, 1'b0, 5'd0, 34'd0, 5'd3, 5'd4);
        #1;
        chk("mr.pre_count", 64'(bus.count_o),   64'd3);
        chk("mr.pre_we",    64'(bus.rf_we3_o),  64'd1);
        chk("mr.pre_addr",  64'(bus.rf_addr3_o), 64'd2);
        chk("mr.pre_hit1",  64'(bus.lk_hit1_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr.we",    64'(bus.rf_we3_o),  64'd0);
        chk("mr.count", 64'(bus.count_o),   64'd0);
        chk("mr.empty", 64'(bus.empty_o),   64'd1);
        chk("mr.hit1",  64'(bus.lk_hit1_o), 64'd0);
        chk("mr.hit2",  64'(bus.lk_hit2_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("mr.post%0d.we", i),    64'(bus.rf_we3_o), 64'd0);
            chk($sformatf("mr.post%0d.count", i), 64'(bus.count_o),  64'd0);
        end

        // Random stream: A every cycle, B at random, against a reference queue
        sb.delete();
        for (int i = 0; i < 200 + 8; i++) begin
            logic        av, bv, exp_ar, exp_br;
            logic [4:0]  aa, ba;
            logic [33:0] ad, bd;
            int          mcnt;
            ent_t        e;
            av = (i < 200);
            bv = (i < 200) && ($urandom_range(0, 1) == 1);
            aa = 5'($urandom_range(0, 31));
            ba = 5'($urandom_range(0, 31));
            ad = {2'($urandom_range(0, 3)), $urandom()};
            bd = {2'($urandom_range(0, 3)), $urandom()};
            @(negedge clk);
            drive(av, aa, ad, bv, ba, bd, 5'd0, 5'd0);
            #1;
            mcnt   = sb.size();
            exp_ar = (mcnt <= DEPTH - 1);
            exp_br = (mcnt <= DEPTH - 2) || ((mcnt == DEPTH - 1) && !av);
            chk($sformatf("rs%0d.count", i), 64'(bus.count_o),   64'(mcnt));
            chk($sformatf("rs%0d.ar", i),    64'(bus.a_ready_o), 64'(exp_ar));
            chk($sformatf("rs%0d.br", i),    64'(bus.b_ready_o), 64'(exp_br));
            chk($sformatf("rs%0d.we", i),    64'(bus.rf_we3_o),  64'(mcnt != 0));
            if (mcnt != 0) begin
                e = sb.pop_front();
                chk($sformatf("rs%0d.addr", i), 64'(bus.rf_addr3_o), 64'(e.addr));
                chk($sformatf("rs%0d.data", i), 64'(bus.rf_data3_o), 64'(e.data));
            end
            if (av && exp_ar) sb.push_back('{addr: aa, data: ad});
            if (bv && exp_br) sb.push_back('{addr: ba, data: bd});
        end
        chk("rs.drained", 64'(sb.size()), 64'd0);
        #1;
        chk("rs.final_empty", 64'(bus.empty_o), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
